// File: rtl/clock_div_ctrl_pkg.sv
// Shared definitions for the clock divider programming controller.
// CLK_DIV is the power-up ratio and must match the value clock_div resets to.
package clock_div_ctrl_pkg;

    localparam int CLK_DIV = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/clock_div_ctrl_dwell.sv
// Loadable down-counter that times how long a new N is held.
// It flags expiry on the cycle the count reaches 1.
module clock_div_ctrl_dwell #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/clock_div_ctrl.sv
// Steps clock_div's N toward a software-written target, holding each value long
// enough for the divider's N synchroniser (clocked by the divided output) to settle.
module clock_div_ctrl
    import clock_div_ctrl_pkg::*;
#(
    parameter int SIZE  = 3,
    parameter int GUARD = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            wr_en,
    input  logic [SIZE-1:0] wr_data,
    input  logic            ramp_en,
    output logic [SIZE-1:0] div_out,
    output logic            busy,
    output logic            done
);

    localparam int DW = SIZE + 2;

    state_t          state, state_nxt;
    logic [SIZE-1:0] target;
    logic [SIZE-1:0] wr_canon;
    logic [SIZE-1:0] step_div;
    logic [DW-1:0]   dwell_val;
    logic            dwell_exp;

    // A ratio of 0 is a bypass just like 1; store it as 1 so div_out never reads 0.
    assign wr_canon = (wr_data == '0) ? SIZE'(1) : wr_data;

    always_comb begin
        step_div = div_out;
        if (!ramp_en) begin
            step_div = target;
        end else if (target > div_out) begin
            step_div = div_out + SIZE'(1);
        end else if (target < div_out) begin
            step_div = div_out - SIZE'(1);
        end
    end

    // Two divided-clock periods plus margin; DW bits hold 2*(2**SIZE-1)+GUARD.
    assign dwell_val = {1'b0, step_div, 1'b0} + DW'(GUARD);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (wr_en) state_nxt = (wr_canon == div_out) ? DONE : STEP;
            end
            STEP: begin
                state_nxt = DWELL;
            end
            DWELL: begin
                if (dwell_exp) state_nxt = (div_out == target) ? DONE : STEP;
            end
            DONE: begin
                if (wr_en) state_nxt = (wr_canon == div_out) ? DONE : STEP;
                else       state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            target  <= SIZE'(CLK_DIV);
            div_out <= SIZE'(CLK_DIV);
        end else begin
            state <= state_nxt;
            // Latest write wins in every state; a running dwell is left untouched.
            if (wr_en) target <= wr_canon;
            if (state == STEP) div_out <= step_div;
        end
    end

    clock_div_ctrl_dwell #(
        .W(DW)
    ) u_dwell (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (state == STEP),
        .load_val (dwell_val),
        .expired  (dwell_exp)
    );

    assign busy = (state == STEP) || (state == DWELL);
    assign done = (state == DONE);

endmodule
